// File: rtl/ram_dp_init.sv
// Simple dual-port RAM: one byte-enabled write port and one registered read port.
// Reads take RD_LATENCY (1 or 2) cycles and are marked by a read-valid strobe.
// A two-state sweep (INIT/IDLE) writes INIT_VALUE to every word after reset or on init_i.
// While the sweep runs, port reads and writes are dropped.
// Optional feature macro: RAM_BYPASS_EN. When it is defined, a read and a write to the
// same address in the same cycle return the new data on the enabled lanes (write-first,
// per lane). When it is undefined, the read returns the old word (read-before-write).
module ram_dp_init #(
   parameter int                    ADDR_WIDTH = 6,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    BYTE_WIDTH = 8,
   parameter int                    RD_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             init_i,
   output logic                             busy_o,
   input  logic                             write_ena_i,
   input  logic [ADDR_WIDTH-1:0]            w_addr_i,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] w_be_i,
   input  logic [DATA_WIDTH-1:0]            bus_data_i,
   input  logic                             read_ena_i,
   input  logic [ADDR_WIDTH-1:0]            r_addr_i,
   output logic [DATA_WIDTH-1:0]            bus_data_o,
   output logic                             read_valid_o
);

   localparam int NBE   = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   // The counter is one bit wider than the address, so the last index never wraps.
   localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

   // Illegal configurations stop elaboration.
   if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $error("ram_dp_init: DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end

   typedef enum logic {
      S_INIT,
      S_IDLE
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
   logic                    port_en;
   logic                    wr_acc;
   logic                    rd_acc;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [DATA_WIDTH-1:0]   s1_data_q;
   logic                    s1_valid_q;

   // Holds the sweep FSM state and the sweep address counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state always uses non-blocking assignments, so every register
      // samples values from before the edge no matter how the blocks are ordered.
      if (!rst_ni) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: sweep one word per cycle; IDLE accepts a new init request.
   always_comb begin
      // NOTE: every output of a comb block gets a default first, so no path leaves it
      // unassigned and no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (init_i) begin
               state_d = S_INIT;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs of the FSM: busy flag and gating of the user ports.
   always_comb begin
      busy_o  = (state_q == S_INIT);
      port_en = (state_q == S_IDLE);
      wr_acc  = port_en & write_ena_i;
      rd_acc  = port_en & read_ena_i;
   end

   // Array writes: the sweep has priority; otherwise byte-enabled port writes.
   always_ff @(posedge clk_i) begin
      // NOTE: the array has no reset. Resetting every word would turn the RAM into
      // flops; the sweep clears it instead.
      if (busy_o) begin
         mem[cnt_q[ADDR_WIDTH-1:0]] <= INIT_VALUE;
      end else if (wr_acc) begin
         for (int k = 0; k < NBE; k++) begin
            if (w_be_i[k]) begin
               mem[w_addr_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= bus_data_i[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // Word seen by the read port, with optional per-lane forwarding of a same-address write.
   always_comb begin
      rd_word = mem[r_addr_i];
`ifdef RAM_BYPASS_EN
      if (wr_acc && (w_addr_i == r_addr_i)) begin
         for (int k = 0; k < NBE; k++) begin
            if (w_be_i[k]) begin
               rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = bus_data_i[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
`endif
   end

   // First read stage: capture the word on an accepted read and hold it otherwise.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_data_q  <= '0;
         s1_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= rd_acc;
         if (rd_acc) begin
            s1_data_q <= rd_word;
         end
      end
   end

   if (RD_LATENCY == 1) begin : g_lat1
      assign bus_data_o   = s1_data_q;
      assign read_valid_o = s1_valid_q;
   end else if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s2_data_q;
      logic                  s2_valid_q;

      // Second read stage: a plain register, so a read can still be issued every cycle.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            s2_data_q  <= '0;
            s2_valid_q <= 1'b0;
         end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_data_q <= s1_data_q;
            end
         end
      end

      assign bus_data_o   = s2_data_q;
      assign read_valid_o = s2_valid_q;
   end else begin : g_bad_latency
      $error("ram_dp_init: RD_LATENCY must be 1 or 2");
   end

endmodule

// File: tb/tb_ram_dp_init.sv
// Bench for ram_dp_init: one instance with RD_LATENCY=1 and one with RD_LATENCY=2 share
// the same stimulus. A behavioural model (word array, sweep countdown, read delay line)
// predicts busy, valid and data for both, and directed sequences add fixed expectations.
module tb_ram_dp_init;

   localparam int          AW   = 6;
   localparam int          DW   = 32;
   localparam int          NW   = 2 ** AW;
   localparam logic [31:0] INIT = 32'hC35A_0FF0;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          init;
   logic          we;
   logic [AW-1:0] wa;
   logic [3:0]    be;
   logic [DW-1:0] wd;
   logic          re;
   logic [AW-1:0] ra;
   logic          busy1, busy2, valid1, valid2;
   logic [DW-1:0] data1, data2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ram_dp_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .RD_LATENCY(1), .INIT_VALUE(INIT)) u_lat1 (
      .clk_i(clk), .rst_ni(rst_n), .init_i(init), .busy_o(busy1),
      .write_ena_i(we), .w_addr_i(wa), .w_be_i(be), .bus_data_i(wd),
      .read_ena_i(re), .r_addr_i(ra), .bus_data_o(data1), .read_valid_o(valid1)
   );

   ram_dp_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .RD_LATENCY(2), .INIT_VALUE(INIT)) u_lat2 (
      .clk_i(clk), .rst_ni(rst_n), .init_i(init), .busy_o(busy2),
      .write_ena_i(we), .w_addr_i(wa), .w_be_i(be), .bus_data_i(wd),
      .read_ena_i(re), .r_addr_i(ra), .bus_data_o(data2), .read_valid_o(valid2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_mem [NW];
   int          m_left;          // sweep cycles still to run; 0 means idle
   logic        p_v0, p_v1;      // read delay line: valid after 1 and 2 cycles
   logic [31:0] p_d0, p_d1;
   logic [31:0] e_d1, e_d2;      // held output word per latency
   logic        r_v;
   logic [31:0] r_w;
   logic        chk_en = 1'b0;

   function automatic logic [31:0] lane_mask(input logic [3:0] b);
      lane_mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
   endfunction

   task automatic model_reset();
      m_left = NW;
      p_v0 = 1'b0; p_v1 = 1'b0; p_d0 = '0; p_d1 = '0;
      e_d1 = '0;   e_d2 = '0;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         r_v = 1'b0;
         r_w = '0;
         if (m_left > 0) begin
            m_mem[NW - m_left] = INIT;
            m_left--;
         end else begin
            if (re) begin
               r_v = 1'b1;
               r_w = m_mem[ra];
`ifdef RAM_BYPASS_EN
               if (we && wa == ra) r_w = (r_w & ~lane_mask(be)) | (wd & lane_mask(be));
`endif
            end
            if (we) m_mem[wa] = (m_mem[wa] & ~lane_mask(be)) | (wd & lane_mask(be));
            if (init) m_left = NW;
         end
         p_v1 = p_v0; p_d1 = p_d0;
         p_v0 = r_v;  p_d0 = r_w;
         if (p_v0) e_d1 = p_d0;
         if (p_v1) e_d2 = p_d1;
      end
   end

   // Every cycle, compare both instances against the model away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy_l1",  {31'b0, busy1},  {31'b0, m_left > 0});
         check("busy_l2",  {31'b0, busy2},  {31'b0, m_left > 0});
         check("valid_l1", {31'b0, valid1}, {31'b0, p_v0});
         check("valid_l2", {31'b0, valid2}, {31'b0, p_v1});
         check("data_l1",  data1, e_d1);
         check("data_l2",  data2, e_d2);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle_inputs();
      init = 1'b0; we = 1'b0; re = 1'b0;
      wa = '0; ra = '0; be = '0; wd = '0;
   endtask

   task automatic write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
      we = 1'b1; wa = a; wd = d; be = b;
      @(negedge clk);
      we = 1'b0;
   endtask

   // Read one address; check the 1-cycle instance, then the 2-cycle instance a cycle later.
   task automatic read_check(input logic [AW-1:0] a, input logic [31:0] exp);
      re = 1'b1; ra = a;
      @(negedge clk);
      re = 1'b0;
      check("rd_valid_l1", {31'b0, valid1}, 32'd1);
      check("rd_data_l1",  data1, exp);
      @(negedge clk);
      check("rd_valid_l2", {31'b0, valid2}, 32'd1);
      check("rd_data_l2",  data2, exp);
   endtask

   // Count cycles until busy falls, bounded; expects the full-depth sweep length.
   task automatic expect_sweep(input string tag);
      int n;
      n = 0;
      while (busy1 && n < 4 * NW) begin
         @(negedge clk);
         n++;
      end
      check(tag, n, NW);
   endtask

   logic [31:0] vals [8];
   logic [31:0] col_exp;
   logic        saw_valid;
   int          n;

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("rst_busy",  {31'b0, busy1},  32'd1);
      check("rst_valid", {31'b0, valid2}, 32'd0);
      check("rst_data",  data1, 32'd0);
      rst_n = 1'b1;

      // Sweep after reset, then every word reads back as INIT.
      expect_sweep("sweep_len_after_reset");
      for (int i = 0; i < NW; i++) read_check(AW'(i), INIT);

      // Byte-lane write merge, 1-cycle read.
      write(6'd5, 32'hDEADBEEF, 4'b1111);
      write(6'd5, 32'h000000AA, 4'b0001);
      read_check(6'd5, 32'hDEADBEAA);
      write(6'd5, 32'h12345678, 4'b0000);
      read_check(6'd5, 32'hDEADBEAA);

      // Back-to-back reads of 0..7; 2-cycle instance strobes 8 times in a row.
      for (int i = 0; i < 8; i++) begin
         vals[i] = $urandom;
         write(AW'(i), vals[i], 4'b1111);
      end
      for (int i = 0; i < 10; i++) begin
         re = (i < 8);
         ra = AW'(i);
         @(negedge clk);
         if (i == 0 || i == 9) check("b2b_gap_l2", {31'b0, valid2}, 32'd0);
         else begin
            check("b2b_valid_l2", {31'b0, valid2}, 32'd1);
            check("b2b_data_l2",  data2, vals[i-1]);
         end
      end
      re = 1'b0;

      // Same-address read and partial write in one cycle.
      write(6'd9, 32'hAABBCCDD, 4'b1111);
`ifdef RAM_BYPASS_EN
      col_exp = 32'hAABB3344;
`else
      col_exp = 32'hAABBCCDD;
`endif
      we = 1'b1; wa = 6'd9; wd = 32'h11223344; be = 4'b0011;
      re = 1'b1; ra = 6'd9;
      @(negedge clk);
      idle_inputs();
      check("collide_l1", data1, col_exp);
      @(negedge clk);
      check("collide_l2", data2, col_exp);
      read_check(6'd9, 32'hAABB3344);

      // Randomised traffic, including same-address collisions and rare init pulses.
      for (int i = 0; i < 800; i++) begin
         we   = 1'($urandom_range(0, 1));
         wa   = AW'($urandom_range(0, 15));
         wd   = $urandom;
         be   = 4'($urandom);
         re   = 1'($urandom_range(0, 1));
         ra   = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 15));
         init = ($urandom_range(0, 299) == 0);
         @(negedge clk);
      end
      idle_inputs();
      n = 0;
      while (busy1 && n < 4 * NW) begin
         @(negedge clk);
         n++;
      end
      check("random_drain", {31'b0, busy1}, 32'd0);

      // Init request: port traffic during the sweep is dropped; a second init does not extend it.
      init = 1'b1;
      @(negedge clk);
      init = 1'b0;
      saw_valid = 1'b0;
      n = 0;
      while (busy1 && n < 4 * NW) begin
         we = 1'b1; wa = AW'($urandom); wd = $urandom; be = 4'hF;
         re = 1'b1; ra = AW'($urandom);
         init = (n == 20);
         @(negedge clk);
         if (busy1 && (valid1 || valid2)) saw_valid = 1'b1;
         n++;
      end
      idle_inputs();
      check("init_sweep_len", n, NW);
      check("init_no_valid", {31'b0, saw_valid}, 32'd0);
      @(negedge clk);
      for (int i = 0; i < NW; i++) read_check(AW'(i), INIT);

      // Asynchronous reset at sweep address 30, then a full restart.
      write(6'd3, 32'h0BADF00D, 4'b1111);
      read_check(6'd3, 32'h0BADF00D);
      init = 1'b1;
      @(negedge clk);
      init = 1'b0;
      repeat (30) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy",   {31'b0, busy1},  32'd1);
      check("midrst_valid",  {31'b0, valid1}, 32'd0);
      check("midrst_data_l1", data1, 32'd0);
      check("midrst_data_l2", data2, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      expect_sweep("sweep_len_after_midrst");
      read_check(6'd0,  INIT);
      read_check(6'd3,  INIT);
      read_check(6'd30, INIT);
      read_check(6'd63, INIT);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
